// File: rtl/im_load_pkg.sv
// Shared types and sizing for the instruction-memory loader (im_load_ctrl).
// Build option: IM_LOAD_CKSUM_EN enables the XOR trailer byte check.
package im_load_pkg;

  localparam int INSTR_W    = 17;
  localparam int ADDR_W     = 11;
  localparam int DEPTH      = 2048;
  localparam int CNT_BYTES  = 2;
  localparam int WORD_BYTES = 3;

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, B0, B1, B2, WR, CKS, DONE, ERR
  } ld_state_t;

endpackage

// File: rtl/im_word_pack.sv
// Assembles one 17-bit instruction from B0..B2 and flags a malformed B0.
// Build option: IM_LOAD_CKSUM_EN adds the running XOR of every shifted byte.
module im_word_pack
  import im_load_pkg::*;
(
  input  logic               clk,
  input  logic               shift_en,
  input  logic               first,
  input  logic [7:0]         byte_in,
`ifdef IM_LOAD_CKSUM_EN
  input  logic               clr,
  output logic [7:0]         cksum,
`endif
  output logic [INSTR_W-1:0] word,
  output logic               fmt_err
);

  logic                          b0_lsb;
  logic [(WORD_BYTES-1)*8-1:0]   lo;

  // B0 contributes only its LSB; the remaining B0 bits must be zero.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      if (first) begin
        b0_lsb  <= byte_in[0];
        fmt_err <= |byte_in[7:1];
      end else begin
        lo <= {lo[7:0], byte_in};
      end
    end
  end

  assign word = {b0_lsb, lo};

`ifdef IM_LOAD_CKSUM_EN
  always_ff @(posedge clk) begin
    if (clr)
      cksum <= '0;
    else if (shift_en)
      cksum <= cksum ^ byte_in;
  end
`endif

endmodule

// File: rtl/im_load_ctrl.sv
// Instruction-memory port owner: CPU fetch passthrough or UART program load.
// Build option: IM_LOAD_CKSUM_EN expects an XOR trailer byte after the last word.
module im_load_ctrl
  import im_load_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_data,
  input  logic               cpu_rd_en,
  input  logic [15:0]        cpu_addr,
  output logic               im_rd_en,
  output logic               im_we,
  output logic [15:0]        im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_stall,
  output logic               cpu_restart,
  output logic               load_busy,
  output logic               load_err
);

  ld_state_t                  state;
  logic [ADDR_W-1:0]          wr_ptr;
  logic [ADDR_W:0]            count;
  logic [7:0]                 cnt_hi;
  logic [CNT_BYTES*8-1:0]     n_q;
  logic [CNT_BYTES*8-1:0]     n_rx;
  logic [CNT_BYTES*8-1:0]     count_nx;
  logic                       we_q, restart_q, err_q;
  logic                       idle, shift_en, first, fmt_err;
  logic [INSTR_W-1:0]         word;

  assign idle     = (state == IDLE);
  assign first    = (state == B0);
  assign shift_en = rx_rdy & ((state == B0) | (state == B1) | (state == B2));
  assign n_rx     = {cnt_hi, rx_data};
  assign count_nx = (CNT_BYTES*8)'(count) + 1'b1;

`ifdef IM_LOAD_CKSUM_EN
  logic [7:0] cksum;
  im_word_pack u_pack (
    .clk(clk), .shift_en(shift_en), .first(first), .byte_in(rx_data),
    .clr(idle & load_req), .cksum(cksum), .word(word), .fmt_err(fmt_err)
  );
`else
  im_word_pack u_pack (
    .clk(clk), .shift_en(shift_en), .first(first), .byte_in(rx_data),
    .word(word), .fmt_err(fmt_err)
  );
`endif

  // Count bytes are pure data: captured without reset, always written before use.
  always_ff @(posedge clk) begin
    if (state == CNT_HI && rx_rdy) cnt_hi <= rx_data;
    if (state == CNT_LO && rx_rdy) n_q    <= n_rx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      we_q      <= 1'b0;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      restart_q <= 1'b0;
      case (state)
        IDLE: if (load_req) begin
          state  <= CNT_HI;
          err_q  <= 1'b0;
          wr_ptr <= '0;
          count  <= '0;
        end
        CNT_HI: if (rx_rdy) state <= CNT_LO;
        CNT_LO: if (rx_rdy) begin
          if (n_rx == '0) begin
            state     <= DONE;
            restart_q <= 1'b1;
          end else if (n_rx > (CNT_BYTES*8)'(DEPTH)) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            state <= B0;
          end
        end
        B0: if (rx_rdy) state <= B1;
        B1: if (rx_rdy) state <= B2;
        B2: if (rx_rdy) begin
          if (fmt_err) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            state <= WR;
            we_q  <= 1'b1;
          end
        end
        WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
          if (count_nx == n_q) begin
`ifdef IM_LOAD_CKSUM_EN
            state <= CKS;
`else
            state     <= DONE;
            restart_q <= 1'b1;
`endif
          end else begin
            state <= B0;
          end
        end
`ifdef IM_LOAD_CKSUM_EN
        CKS: if (rx_rdy) begin
          if (rx_data == cksum) begin
            state     <= DONE;
            restart_q <= 1'b1;
          end else begin
            state <= ERR;
            err_q <= 1'b1;
          end
        end
`endif
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port mux: CPU owns the IM in IDLE, the loader's write port in WR.
  always_comb begin
    im_addr = '0;
    if (idle)
      im_addr = cpu_addr;
    else if (we_q)
      im_addr = {{(16-ADDR_W){1'b0}}, wr_ptr};
  end

  assign im_rd_en    = idle & cpu_rd_en;
  assign im_we       = we_q;
  assign im_wdata    = we_q ? word : '0;
  assign cpu_stall   = ~idle | load_req;
  assign cpu_restart = restart_q;
  assign load_busy   = ~idle;
  assign load_err    = err_q;

endmodule

// File: tb/tb_im_load_ctrl.sv
// Randomized bench for im_load_ctrl against a frame-level reference model.
// Build option: IM_LOAD_CKSUM_EN adds trailer bytes to every generated frame.
`timescale 1ns/1ps
module tb_im_load_ctrl;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        cpu_rd_en = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        im_rd_en, im_we, cpu_stall, cpu_restart, load_busy, load_err;
  logic [15:0] im_addr;
  logic [16:0] im_wdata;

  int n_vec = 0;
  int n_err = 0;
  int viol = 0;
  int restart_cnt = 0;
  logic [15:0] obs_a[$];
  logic [16:0] obs_d[$];
  logic [16:0] exp_w[$];
  bit exp_err, exp_done;

  im_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .cpu_rd_en(cpu_rd_en), .cpu_addr(cpu_addr), .im_rd_en(im_rd_en), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_stall(cpu_stall),
    .cpu_restart(cpu_restart), .load_busy(load_busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IM write port and protocol invariants observed away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        obs_a.push_back(im_addr);
        obs_d.push_back(im_wdata);
      end
      if (cpu_restart) restart_cnt++;
      if (load_busy && !cpu_stall) viol++;
      if (load_busy && im_rd_en) viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret the frame byte-by-byte from the framing rules.
  task automatic model(input bq_t s);
    int n;
    logic [7:0] x, b0;
    exp_w.delete();
    exp_err  = 0;
    exp_done = 0;
    n = {s[0], s[1]};
    x = '0;
    if (n == 0) exp_done = 1;
    else if (n > 2048) exp_err = 1;
    else begin
      for (int i = 0; i < n; i++) begin
        b0 = s[2+3*i];
        if (b0[7:1] != 0) begin
          exp_err = 1;
          break;
        end
        exp_w.push_back({b0[0], s[3+3*i], s[4+3*i]});
        x = x ^ b0 ^ s[3+3*i] ^ s[4+3*i];
      end
      if (!exp_err) begin
`ifdef IM_LOAD_CKSUM_EN
        if (s[2+3*n] == x) exp_done = 1;
        else exp_err = 1;
`else
        exp_done = 1;
`endif
      end
    end
  endtask

  task automatic run_load(input string tag, input bq_t s);
    model(s);
    obs_a.delete();
    obs_d.delete();
    restart_cnt = 0;
    load_req = 1'b1;
    #1;
    chk({tag, "_stall_req"}, cpu_stall, 1);
    tick();
    load_req = 1'b0;
    chk({tag, "_err_clr"}, load_err, 0);
    foreach (s[i]) begin
      repeat (3) tick();
      rx_data = s[i];
      rx_rdy  = 1'b1;
      tick();
      rx_rdy  = 1'b0;
    end
    for (int k = 0; k < 50 && load_busy; k++) tick();
    chk({tag, "_busy_end"}, load_busy, 0);
    tick();
    chk({tag, "_nwr"}, obs_d.size(), exp_w.size());
    foreach (exp_w[i]) begin
      if (i < obs_d.size()) begin
        chk($sformatf("%s_a%0d", tag, i), obs_a[i], i);
        chk($sformatf("%s_d%0d", tag, i), obs_d[i], exp_w[i]);
      end
    end
    chk({tag, "_restart"}, restart_cnt, exp_done ? 1 : 0);
    chk({tag, "_err"}, load_err, exp_err);
  endtask

  function automatic bq_t gen(input int n, input int bad);
    bq_t s;
    logic [7:0] x = '0;
    logic [7:0] b;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 3; j++) begin
        b = 8'($urandom);
        if (j == 0) b = (i == bad) ? {7'($urandom_range(1, 127)), b[0]} : {7'd0, b[0]};
        s.push_back(b);
        x ^= b;
      end
    end
`ifdef IM_LOAD_CKSUM_EN
    s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h5A) : x);
`endif
    return s;
  endfunction

  initial begin
    bq_t s;
    int n;
    // Reset state
    #2;
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_restart", cpu_restart, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_err", load_err, 0);
    chk("rst_rd", im_rd_en, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Idle passthrough
    cpu_rd_en = 1'b1;
    cpu_addr  = 16'h0042;
    #1;
    chk("pt_rd", im_rd_en, 1);
    chk("pt_addr", im_addr, 16'h0042);
    chk("pt_we", im_we, 0);
    chk("pt_stall", cpu_stall, 0);
    tick();
    cpu_rd_en = 1'b0;
    cpu_addr  = '0;

    // Directed N=2 frame with known packing
    s = '{8'h00, 8'h02, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h12, 8'h34};
`ifdef IM_LOAD_CKSUM_EN
    s.push_back(8'h41);
`endif
    run_load("n2", s);
    chk("n2_w0", obs_d.size() > 0 ? obs_d[0] : 17'h0, 17'h1ABCD);
    chk("n2_w1", obs_d.size() > 1 ? obs_d[1] : 17'h0, 17'h01234);
`ifdef IM_LOAD_CKSUM_EN
    s[8] = 8'h00;
    run_load("n2_badck", s);
`endif

    run_load("n0", '{8'h00, 8'h00});
    run_load("ovf", '{8'h08, 8'h01});
    run_load("after_ovf", '{8'h00, 8'h00});
    run_load("badb0", gen(3, 1));

    // Randomized frames, some with malformed B0 or oversize counts
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(2049, 65535);
        s = '{8'(n >> 8), 8'(n)};
      end else begin
        n = $urandom_range(1, 5);
        s = gen(n, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1);
      end
      run_load($sformatf("rnd%0d", t), s);
    end

    // Async reset mid-load
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    s = '{8'h00, 8'h02, 8'h01, 8'hAB};
    foreach (s[i]) begin
      repeat (3) tick();
      rx_data = s[i];
      rx_rdy  = 1'b1;
      tick();
      rx_rdy  = 1'b0;
    end
    chk("mid_busy", load_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", load_busy, 0);
    chk("ar_stall", cpu_stall, 0);
    chk("ar_we", im_we, 0);
    chk("ar_addr", im_addr, 0);
    chk("ar_restart", cpu_restart, 0);
    tick();
    rst_n = 1'b1;
    cpu_rd_en = 1'b1;
    cpu_addr  = 16'h0123;
    tick();
    chk("ar_pt_rd", im_rd_en, 1);
    chk("ar_pt_addr", im_addr, 16'h0123);

    chk("invariants", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
